serial_xs3_bcd_codec: RTL and testbench

//  Bit-serial, LSB-first, bidirectional decimal code converter: Excess-3 -> BCD (subtract 3) or BCD -> Excess-3 (add 3).

---
 rtl/serial_codec_pkg.sv | 23 ++
 rtl/serial_add3_slice.sv | 41 ++++
 rtl/serial_xs3_bcd_codec.sv | 96 +++++++++
 tb/tb_serial_xs3_bcd_codec.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_codec_pkg.sv
// Shared constants and digit-validity helper for the bit-serial XS3/BCD codec.
package serial_codec_pkg;

    localparam logic MODE_XS3_TO_BCD = 1'b0;
    localparam logic MODE_BCD_TO_XS3 = 1'b1;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] XS3_MIN = 4'd3;
    localparam logic [DIGIT_W-1:0] XS3_MAX = 4'd12;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] BIT_LAST = 2'd3;

    // True when a completed digit is not a legal code for the active conversion direction.
    function automatic logic digit_invalid(input logic em, input logic [DIGIT_W-1:0] v);
        if (em == MODE_BCD_TO_XS3) begin
            return v > BCD_MAX;
        end
        return (v < XS3_MIN) || (v > XS3_MAX);
    endfunction

endpackage

// File: rtl/serial_add3_slice.sv
// One bit of the serial +3 / -3 datapath: converted bit and next carry/borrow.
module serial_add3_slice
    import serial_codec_pkg::*;
(
    input  logic       x,
    input  logic [1:0] bp,
    input  logic       cb,
    input  logic       em,
    output logic       z,
    output logic       cb_nxt
);

    logic add;

    assign add = (em == MODE_BCD_TO_XS3);

    // Constant 0011: bits 0 and 1 add/subtract a one, bits 2 and 3 only propagate.
    always_comb begin
        z      = 1'b0;
        cb_nxt = 1'b0;
        case (bp)
            2'd0: begin
                z      = ~x;
                cb_nxt = add ? x : ~x;
            end
            2'd1: begin
                z      = ~(x ^ cb);
                cb_nxt = add ? (x | cb) : (~x | cb);
            end
            2'd2: begin
                z      = x ^ cb;
                cb_nxt = add ? (x & cb) : (~x & cb);
            end
            default: begin
                z      = x ^ cb;
                cb_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_xs3_bcd_codec.sv
// Bit-serial LSB-first Excess-3 <-> BCD converter with per-digit and per-word error flags.
module serial_xs3_bcd_codec
    import serial_codec_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned ERR_ZERO = 0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    input  logic En,
    input  logic Mode,
    output logic Z,
    output logic ZValid,
    output logic DigitDone,
    output logic Err,
    output logic WordDone,
    output logic WordErr
);

    localparam int unsigned    DI_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DI_W-1:0] DI_LAST = DI_W'(DIGITS - 1);

    logic [1:0]      bp;
    logic [DI_W-1:0] di;
    logic            cb;
    logic            lm;
    logic            ea;
    logic [2:0]      p;

    logic word_start;
    logic em;
    logic bit_last;
    logic invalid;
    logic z_raw;
    logic cb_nxt;
    logic force_zero;

    // Mode is taken live on the very first bit of a word, from the latch afterwards.
    assign word_start = (bp == 2'd0) && (di == '0);
    assign em         = word_start ? Mode : lm;
    assign bit_last   = (bp == BIT_LAST);
    assign invalid    = digit_invalid(em, {X, p});

    serial_add3_slice u_slice (
        .x      (X),
        .bp     (bp),
        .cb     (cb),
        .em     (em),
        .z      (z_raw),
        .cb_nxt (cb_nxt)
    );

    assign force_zero = (ERR_ZERO != 0) && bit_last && invalid;
    assign Z          = En & z_raw & ~force_zero;
    assign ZValid     = En;
    assign DigitDone  = En & bit_last;
    assign Err        = DigitDone & invalid;
    assign WordDone   = DigitDone & (di == DI_LAST);

    // All state advances only on a consumed bit; gaps (En=0) freeze everything.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bp      <= 2'd0;
            di      <= '0;
            cb      <= 1'b0;
            lm      <= MODE_XS3_TO_BCD;
            ea      <= 1'b0;
            p       <= 3'd0;
            WordErr <= 1'b0;
        end else if (En) begin
            bp <= bp + 2'd1;
            cb <= bit_last ? 1'b0 : cb_nxt;
            if (word_start) begin
                lm <= Mode;
            end
            case (bp)
                2'd0:    p[0] <= X;
                2'd1:    p[1] <= X;
                2'd2:    p[2] <= X;
                default: p    <= p;
            endcase
            if (bit_last) begin
                if (di == DI_LAST) begin
                    di      <= '0;
                    ea      <= 1'b0;
                    WordErr <= ea | invalid;
                end else begin
                    di <= di + DI_W'(1);
                    ea <= ea | invalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_xs3_bcd_codec.sv
// Directed bench: three codec instances (1 digit, 3 digits, 1 digit with forced-zero errors) on shared stimulus.
module tb_serial_xs3_bcd_codec;

    logic Clk = 1'b0;
    logic Rst;
    logic X;
    logic En;
    logic Mode;

    logic a_z, a_zv, a_dd, a_err, a_wd, a_we;
    logic b_z, b_zv, b_dd, b_err, b_wd, b_we;
    logic c_z, c_zv, c_dd, c_err, c_wd, c_we;

    always #5 Clk = ~Clk;

    serial_xs3_bcd_codec #(.DIGITS(1), .ERR_ZERO(0)) u_d1 (
        .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Mode(Mode),
        .Z(a_z), .ZValid(a_zv), .DigitDone(a_dd), .Err(a_err), .WordDone(a_wd), .WordErr(a_we)
    );

    serial_xs3_bcd_codec #(.DIGITS(3), .ERR_ZERO(0)) u_d3 (
        .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Mode(Mode),
        .Z(b_z), .ZValid(b_zv), .DigitDone(b_dd), .Err(b_err), .WordDone(b_wd), .WordErr(b_we)
    );

    serial_xs3_bcd_codec #(.DIGITS(1), .ERR_ZERO(1)) u_ez (
        .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Mode(Mode),
        .Z(c_z), .ZValid(c_zv), .DigitDone(c_dd), .Err(c_err), .WordDone(c_wd), .WordErr(c_we)
    );

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] zexp;
        logic       err;
    } vec_t;

    vec_t tv[40];
    int   ntv;
    int   tests = 0;
    int   fails = 0;

    // Per-digit captures, bit i of each vector is the sample taken while bit i was presented.
    logic [3:0] a_zn, a_zvn, a_ddn, a_errn, a_wdn, a_wen;
    logic [3:0] b_zn, b_ddn, b_wdn, b_errn;
    logic [3:0] c_zn, c_errn;
    int         b_dd_cnt, b_wd_cnt, b_err_cnt;
    logic       gap_bad;
    logic [11:0] s_ref, s_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic x, input logic m);
        @(negedge Clk);
        X    = x;
        En   = 1'b1;
        Mode = m;
        #1;
    endtask

    task automatic idle();
        @(negedge Clk);
        En = 1'b0;
        #1;
    endtask

    task automatic clear_counts();
        b_dd_cnt  = 0;
        b_wd_cnt  = 0;
        b_err_cnt = 0;
        gap_bad   = 1'b0;
    endtask

    // One digit, bits LSB first, per-bit mode in mv, random idle cycles (0..gapmax) before each bit.
    task automatic send_digit(input logic [3:0] mv, input logic [3:0] d, input int gapmax);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                @(negedge Clk);
                En = 1'b0;
                X  = 1'($urandom);
                #1;
                if (a_z | a_zv | a_dd | b_z | b_zv | b_dd | b_wd | c_z | c_zv) gap_bad = 1'b1;
            end
            send_bit(d[i], mv[i]);
            a_zn[i] = a_z;  a_zvn[i] = a_zv; a_ddn[i] = a_dd;
            a_errn[i] = a_err; a_wdn[i] = a_wd; a_wen[i] = a_we;
            b_zn[i] = b_z;  b_ddn[i] = b_dd; b_wdn[i] = b_wd; b_errn[i] = b_err;
            c_zn[i] = c_z;  c_errn[i] = c_err;
            b_dd_cnt  += int'(b_dd);
            b_wd_cnt  += int'(b_wd);
            b_err_cnt += int'(b_err);
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        En  = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        #1;
        check("rst_worderr_d3", 32'(b_we), 32'd0);
        check("rst_worderr_d1", 32'(a_we), 32'd0);
        check("rst_zvalid", 32'({a_zv, b_zv, c_zv}), 32'd0);
        Rst = 1'b1;
    endtask

    initial begin
        Rst  = 1'b0;
        X    = 1'b0;
        En   = 1'b0;
        Mode = 1'b0;

        // Table: hand vectors first, then the valid-code sweeps.
        ntv = 0;
        tv[ntv++] = '{1'b0, 4'b0101, 4'b0010, 1'b0};
        tv[ntv++] = '{1'b1, 4'b0111, 4'b1010, 1'b0};
        tv[ntv++] = '{1'b0, 4'b0001, 4'b1110, 1'b1};
        tv[ntv++] = '{1'b0, 4'b1000, 4'b0101, 1'b0};
        tv[ntv++] = '{1'b0, 4'b0000, 4'b1101, 1'b1};
        tv[ntv++] = '{1'b0, 4'b1101, 4'b1010, 1'b1};
        tv[ntv++] = '{1'b0, 4'b1111, 4'b1100, 1'b1};
        tv[ntv++] = '{1'b1, 4'b1010, 4'b1101, 1'b1};
        tv[ntv++] = '{1'b1, 4'b1100, 4'b1111, 1'b1};
        tv[ntv++] = '{1'b1, 4'b1111, 4'b0010, 1'b1};
        for (int v = 0; v < 10; v++) tv[ntv++] = '{1'b1, 4'(v), 4'(v + 3), 1'b0};
        for (int v = 3; v < 13; v++) tv[ntv++] = '{1'b0, 4'(v), 4'(v - 3), 1'b0};

        #12;
        check("reset_worderr", 32'({a_we, b_we, c_we}), 32'd0);
        check("reset_comb", 32'({a_z, a_zv, a_dd, a_err, a_wd}), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        for (int k = 0; k < ntv; k++) begin
            logic [3:0] ez_exp;
            ez_exp = tv[k].err ? (tv[k].zexp & 4'b0111) : tv[k].zexp;
            send_digit({4{tv[k].mode}}, tv[k].din, 0);
            check($sformatf("vec%0d_z", k), 32'(a_zn), 32'(tv[k].zexp));
            check($sformatf("vec%0d_zvalid", k), 32'(a_zvn), 32'hF);
            check($sformatf("vec%0d_digitdone", k), 32'(a_ddn), 32'h8);
            check($sformatf("vec%0d_worddone", k), 32'(a_wdn), 32'h8);
            check($sformatf("vec%0d_err", k), 32'(a_errn), 32'({tv[k].err, 3'b000}));
            check($sformatf("vec%0d_ez_z", k), 32'(c_zn), 32'(ez_exp));
            idle();
            check($sformatf("vec%0d_worderr", k), 32'(a_we), 32'(tv[k].err));
            check($sformatf("vec%0d_ez_worderr", k), 32'(c_we), 32'(tv[k].err));
        end

        // WordErr set by an invalid word holds through the next word until its WordDone.
        send_digit(4'b0000, 4'b0001, 0);
        idle();
        check("t3_worderr_set", 32'(a_we), 32'd1);
        send_digit(4'b0000, 4'b0110, 3);
        check("t3_worderr_hold", 32'(a_wen), 32'hF);
        check("t3_valid_z", 32'(a_zn), 32'd3);
        idle();
        check("t3_worderr_clear", 32'(a_we), 32'd0);

        // Three-digit words: gapless reference, then the same word with random gaps.
        pulse_reset();
        clear_counts();
        send_digit(4'b1111, 4'd2, 0); s_ref[3:0]  = b_zn;
        send_digit(4'b1111, 4'd5, 0); s_ref[7:4]  = b_zn;
        send_digit(4'b1111, 4'd9, 0); s_ref[11:8] = b_zn;
        check("t4_ref_stream", 32'(s_ref), 32'({4'd12, 4'd8, 4'd5}));
        check("t4_ref_dd", 32'(b_dd_cnt), 32'd3);
        check("t4_ref_wd", 32'(b_wd_cnt), 32'd1);
        check("t4_ref_wd_pos", 32'(b_wdn), 32'h8);
        clear_counts();
        send_digit(4'b1111, 4'd2, 5); s_gap[3:0]  = b_zn;
        send_digit(4'b1111, 4'd5, 5); s_gap[7:4]  = b_zn;
        send_digit(4'b1111, 4'd9, 5); s_gap[11:8] = b_zn;
        check("t4_gap_stream", 32'(s_gap), 32'(s_ref));
        check("t4_gap_dd", 32'(b_dd_cnt), 32'd3);
        check("t4_gap_wd", 32'(b_wd_cnt), 32'd1);
        check("t4_gap_idle_outputs", 32'(gap_bad), 32'd0);
        idle();
        check("t4_worderr", 32'(b_we), 32'd0);

        // Mode flips to 1 from word bit 6 onward; word stays XS3->BCD.
        clear_counts();
        send_digit(4'b0000, 4'd6, 0); s_gap[3:0]  = b_zn;
        send_digit(4'b1100, 4'd7, 0); s_gap[7:4]  = b_zn;
        send_digit(4'b1111, 4'd8, 0); s_gap[11:8] = b_zn;
        check("t5_stream", 32'(s_gap), 32'({4'd5, 4'd4, 4'd3}));
        check("t5_err_cnt", 32'(b_err_cnt), 32'd0);
        idle();
        check("t5_worderr", 32'(b_we), 32'd0);

        // Error on the middle digit of a three-digit word.
        clear_counts();
        send_digit(4'b0000, 4'd4, 2); s_gap[3:0] = b_zn;
        send_digit(4'b0000, 4'd2, 2); s_gap[7:4] = b_zn;
        check("t4e_mid_err", 32'(b_errn), 32'h8);
        send_digit(4'b0000, 4'd7, 2); s_gap[11:8] = b_zn;
        check("t4e_stream", 32'(s_gap), 32'({4'd4, 4'd15, 4'd1}));
        check("t4e_err_cnt", 32'(b_err_cnt), 32'd1);
        idle();
        check("t4e_worderr", 32'(b_we), 32'd1);

        // Reset after bit 2 of digit 1 abandons the word and clears WordErr.
        send_digit(4'b1111, 4'd3, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        pulse_reset();
        clear_counts();
        send_digit(4'b1111, 4'd1, 0); s_gap[3:0]  = b_zn;
        check("t6_first_dd", 32'(b_ddn), 32'h8);
        check("t6_first_wd", 32'(b_wdn), 32'h0);
        send_digit(4'b1111, 4'd2, 0); s_gap[7:4]  = b_zn;
        send_digit(4'b1111, 4'd3, 0); s_gap[11:8] = b_zn;
        check("t6_stream", 32'(s_gap), 32'({4'd6, 4'd5, 4'd4}));
        check("t6_dd", 32'(b_dd_cnt), 32'd3);
        check("t6_wd", 32'(b_wd_cnt), 32'd1);
        check("t6_wd_pos", 32'(b_wdn), 32'h8);
        idle();
        check("t6_worderr", 32'(b_we), 32'd0);
        send_digit(4'b1111, 4'b1100, 0);
        check("t6_ez_z", 32'(c_zn), 32'b0111);
        check("t6_raw_z", 32'(a_zn), 32'b1111);
        check("t6_ez_err", 32'(c_errn), 32'h8);
        idle();
        check("t6_ez_worderr", 32'(c_we), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
